// File: rtl/vga_cursor_ctrl_if.sv
// Host command bus for the text-mode cursor controller.
//
// Handshake: the host drives i_cmd_valid together with i_cmd/i_cmd_col/i_cmd_row
// and holds all of them stable until it samples o_cmd_ready=1 on a rising edge.
// A command is consumed on exactly the edge where i_cmd_valid & o_cmd_ready.
// The controller never consumes anything while o_cmd_ready=0.
interface vga_cursor_ctrl_if #(
    parameter int COL_W = 7,
    parameter int ROW_W = 5
);
    logic             i_cmd_valid;
    logic [2:0]       i_cmd;
    logic [COL_W-1:0] i_cmd_col;
    logic [ROW_W-1:0] i_cmd_row;
    logic             o_cmd_ready;

    modport master (
        output i_cmd_valid, i_cmd, i_cmd_col, i_cmd_row,
        input  o_cmd_ready
    );

    modport slave (
        input  i_cmd_valid, i_cmd, i_cmd_col, i_cmd_row,
        output o_cmd_ready
    );
endinterface

// File: rtl/vga_cursor_ctrl.sv
// Text-mode cursor position owner for the 80x25 VGA text controller.
// Keeps row/column, publishes the registered linear cursor address,
// requests a one-line scroll when the cursor leaves the bottom row,
// produces the blink phase and the final cursor-visible gate.
module vga_cursor_ctrl #(
    parameter int COLS         = 80,
    parameter int ROWS         = 25,
    parameter int COL_W        = 7,
    parameter int ROW_W        = 5,
    parameter int ADDR_W       = 11,
    parameter int BLINK_FRAMES = 16
) (
    input  logic               i_clk,
    input  logic               i_rst,
    vga_cursor_ctrl_if.slave   cmd_bus,
    output logic               o_scroll_req,
    input  logic               i_scroll_ack,
    input  logic               i_frame_start,
    input  logic               i_cursor_en,
    input  logic               i_cmp_ok_h,
    output logic [COL_W-1:0]   o_cur_col,
    output logic [ROW_W-1:0]   o_cur_row,
    output logic [ADDR_W-1:0]  o_cur_pos_addr,
    output logic               o_blink_phase,
    output logic               o_cur_visible,
    output logic               o_dbg_state     // 1 = waiting for scroll ack
);

    localparam logic [2:0] CMD_NOP   = 3'd0;
    localparam logic [2:0] CMD_SET   = 3'd1;
    localparam logic [2:0] CMD_RIGHT = 3'd2;
    localparam logic [2:0] CMD_LEFT  = 3'd3;
    localparam logic [2:0] CMD_UP    = 3'd4;
    localparam logic [2:0] CMD_DOWN  = 3'd5;
    localparam logic [2:0] CMD_CR    = 3'd6;
    localparam logic [2:0] CMD_LF    = 3'd7;

    localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [COL_W-1:0]  COL_LAST = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0]  ROW_LAST = ROW_W'(ROWS - 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(BLINK_FRAMES - 1);
    localparam logic [ADDR_W-1:0] COLS_A   = ADDR_W'(COLS);

    typedef enum logic {
        IDLE        = 1'b0,
        SCROLL_WAIT = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [COL_W-1:0]   col_q, col_d;
    logic [ROW_W-1:0]   row_q, row_d;
    logic [ADDR_W-1:0]  addr_q;
    logic [CNT_W-1:0]   blink_cnt_q;
    logic               phase_q;
    logic               cmd_fire;
    logic               blink_restart;

    assign cmd_fire      = cmd_bus.i_cmd_valid && (state_q == IDLE);
    assign blink_restart = cmd_fire && (cmd_bus.i_cmd != CMD_NOP);

    // Next-state and next-position decode for the command FSM
    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        case (state_q)
            IDLE: begin
                if (cmd_bus.i_cmd_valid) begin
                    case (cmd_bus.i_cmd)
                        CMD_SET: begin
                            col_d = (cmd_bus.i_cmd_col > COL_LAST) ? COL_LAST : cmd_bus.i_cmd_col;
                            row_d = (cmd_bus.i_cmd_row > ROW_LAST) ? ROW_LAST : cmd_bus.i_cmd_row;
                        end
                        CMD_RIGHT: begin
                            if (col_q < COL_LAST) begin
                                col_d = col_q + 1'b1;
                            end else begin
                                // Wrap behaves like CR+LF, including the scroll at the bottom row
                                col_d = '0;
                                if (row_q < ROW_LAST) row_d = row_q + 1'b1;
                                else                  state_d = SCROLL_WAIT;
                            end
                        end
                        CMD_LEFT: begin
                            if (col_q != '0) begin
                                col_d = col_q - 1'b1;
                            end else if (row_q != '0) begin
                                col_d = COL_LAST;
                                row_d = row_q - 1'b1;
                            end
                        end
                        CMD_UP: begin
                            if (row_q != '0) row_d = row_q - 1'b1;
                        end
                        CMD_DOWN: begin
                            if (row_q < ROW_LAST) row_d = row_q + 1'b1;
                        end
                        CMD_CR: begin
                            col_d = '0;
                        end
                        CMD_LF: begin
                            if (row_q < ROW_LAST) row_d = row_q + 1'b1;
                            else                  state_d = SCROLL_WAIT;
                        end
                        default: ;
                    endcase
                end
            end
            SCROLL_WAIT: begin
                if (i_scroll_ack) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM state and cursor position registers
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
            col_q   <= '0;
            row_q   <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
        end
    end

    // Linear address follows the position one edge later; row*COLS fits ADDR_W
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) addr_q <= '0;
        else       addr_q <= ADDR_W'(row_q) * COLS_A + ADDR_W'(col_q);
    end

    // Blink counter: frames advance it, accepted non-NOP commands restart it solid
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            blink_cnt_q <= '0;
            phase_q     <= 1'b1;
        end else if (blink_restart) begin
            blink_cnt_q <= '0;
            phase_q     <= 1'b1;
        end else if (i_frame_start) begin
            if (blink_cnt_q == CNT_LAST) begin
                blink_cnt_q <= '0;
                phase_q     <= ~phase_q;
            end else begin
                blink_cnt_q <= blink_cnt_q + 1'b1;
            end
        end
    end

    assign cmd_bus.o_cmd_ready = (state_q == IDLE);
    assign o_scroll_req        = (state_q == SCROLL_WAIT);
    assign o_dbg_state         = (state_q == SCROLL_WAIT);
    assign o_cur_col           = col_q;
    assign o_cur_row           = row_q;
    assign o_cur_pos_addr      = addr_q;
    assign o_blink_phase       = phase_q;
    assign o_cur_visible       = i_cursor_en & phase_q & i_cmp_ok_h;

endmodule
